// File: rtl/buffer_arb_pkg.sv
// buffer_arb_pkg: default widths, index-width helper and response tag type for buffer_port_arbiter
package buffer_arb_pkg;
    localparam int NUM_REQ  = 4;
    localparam int ADDR_LEN = 6;
    localparam int DATA_LEN = 32;

    function automatic int id_len(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_LEN = id_len(NUM_REQ);

    typedef struct packed {
        logic              valid;
        logic [ID_LEN-1:0] id;
    } rsp_tag_t;
endpackage

// File: rtl/buffer.sv
// buffer: simple-dual-port RAM, synchronous write, registered read-before-write output
module buffer #(
    parameter int    addrLen  = 6,
    parameter int    dataLen  = 32,
    parameter string ram_type = "distributed"
) (
    input  logic               clk,
    input  logic               wrt,
    input  logic [addrLen-1:0] wr_addr,
    input  logic [dataLen-1:0] wr_data,
    input  logic [addrLen-1:0] rd_addr,
    output logic [dataLen-1:0] data_out
);
    (* ram_style = ram_type *) logic [dataLen-1:0] mem [2**addrLen];

    // write port and registered read port; a same-address read sees the old word
    always_ff @(posedge clk) begin
        if (wrt) mem[wr_addr] <= wr_data;
        data_out <= mem[rd_addr];
    end
endmodule

// File: rtl/buffer_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered rotating priority pointer
module rr_arbiter #(
    parameter int numReq = 4,
    parameter int idLen  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [numReq-1:0] req,
    output logic [numReq-1:0] gnt,
    output logic [idLen-1:0]  gnt_id,
    output logic              gnt_valid
);
    logic [idLen-1:0] ptr;

    // first requester found searching upward from ptr wins; nothing is granted during reset
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < numReq; k++) begin
            if (!reset && !gnt_valid && req[(int'(ptr) + k) % numReq]) begin
                gnt[(int'(ptr) + k) % numReq] = 1'b1;
                gnt_id    = idLen'((int'(ptr) + k) % numReq);
                gnt_valid = 1'b1;
            end
        end
    end

    // pointer moves just past the last winner, so every requester is served within numReq-1 grants
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (gnt_valid) ptr <= (gnt_id == idLen'(numReq - 1)) ? '0 : gnt_id + 1'b1;
    end
endmodule

// File: rtl/buffer_port_arbiter.sv
// buffer_port_arbiter: shares one buffer between numReq clients with independent RR write/read arbitration.
// Optional BUF_ARB_BYPASS_EN forwards same-cycle write data to a colliding read.
module buffer_port_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int    numReq   = NUM_REQ,
    parameter int    idLen    = id_len(numReq),
    parameter int    addrLen  = ADDR_LEN,
    parameter int    dataLen  = DATA_LEN,
    parameter string ram_type = "distributed"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [numReq-1:0]         wr_req,
    input  logic [numReq*addrLen-1:0] wr_addr,
    input  logic [numReq*dataLen-1:0] wr_data,
    output logic [numReq-1:0]         wr_gnt,
    input  logic [numReq-1:0]         rd_req,
    input  logic [numReq*addrLen-1:0] rd_addr,
    output logic [numReq-1:0]         rd_gnt,
    output logic                      rd_rsp_valid,
    output logic [idLen-1:0]          rd_rsp_id,
    output logic [dataLen-1:0]        rd_rsp_data
);
    logic [idLen-1:0]   wr_id, rd_id;
    logic               wr_v, rd_v;
    logic [addrLen-1:0] b_wr_addr, b_rd_addr;
    logic [dataLen-1:0] b_wr_data, b_rd_data;
    rsp_tag_t           tag_q;

    rr_arbiter #(.numReq(numReq), .idLen(idLen)) u_wr_arb (
        .clk(clk), .reset(reset), .req(wr_req), .gnt(wr_gnt), .gnt_id(wr_id), .gnt_valid(wr_v)
    );

    rr_arbiter #(.numReq(numReq), .idLen(idLen)) u_rd_arb (
        .clk(clk), .reset(reset), .req(rd_req), .gnt(rd_gnt), .gnt_id(rd_id), .gnt_valid(rd_v)
    );

    assign b_wr_addr = wr_addr[wr_id*addrLen +: addrLen];
    assign b_wr_data = wr_data[wr_id*dataLen +: dataLen];
    assign b_rd_addr = rd_addr[rd_id*addrLen +: addrLen];

    buffer #(.addrLen(addrLen), .dataLen(dataLen), .ram_type(ram_type)) u_buf (
        .clk(clk), .wrt(wr_v), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr(b_rd_addr), .data_out(b_rd_data)
    );

    // response tag travels alongside the registered RAM read
    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else begin
            tag_q.valid <= rd_v;
            tag_q.id    <= ID_LEN'(rd_id);
        end
    end

    assign rd_rsp_valid = tag_q.valid;
    assign rd_rsp_id    = idLen'(tag_q.id);

`ifdef BUF_ARB_BYPASS_EN
    logic               byp_hit;
    logic [dataLen-1:0] byp_data;

    // remember a same-cycle write/read address match so the fresh write data replaces the stale RAM word
    always_ff @(posedge clk) begin
        byp_hit  <= wr_v && rd_v && (b_wr_addr == b_rd_addr);
        byp_data <= b_wr_data;
    end

    assign rd_rsp_data = byp_hit ? byp_data : b_rd_data;
`else
    assign rd_rsp_data = b_rd_data;
`endif
endmodule

// File: tb/tb_buffer_port_arbiter.sv
// tb_buffer_port_arbiter: directed self-checking bench for buffer_port_arbiter
module tb_buffer_port_arbiter;
    localparam int N = 4;
    localparam int AL = 6;
    localparam int DL = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
    logic [N*AL-1:0] wr_addr, rd_addr;
    logic [N*DL-1:0] wr_data;
    logic            rd_rsp_valid;
    logic [1:0]      rd_rsp_id;
    logic [DL-1:0]   rd_rsp_data;
    int              checks = 0;
    int              errors = 0;

    buffer_port_arbiter dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_id(rd_rsp_id), .rd_rsp_data(rd_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        wr_req = '1; rd_req = '1;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wr_gnt", 64'(wr_gnt), 64'h0);
            chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
            chk("rst_rsp_valid", 64'(rd_rsp_valid), 64'h0);
        end
        chk("rst_rsp_id", 64'(rd_rsp_id), 64'h0);
        reset = 1'b0;
        #1;
        chk("first_wr_gnt", 64'(wr_gnt), 64'h1);
        wr_req = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_rd_gnt", 64'(rd_gnt), 64'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_rsp_valid", 64'(rd_rsp_valid), 64'h1);
                chk("rr_rsp_id", 64'(rd_rsp_id), 64'((k - 1) % 4));
            end
            tick();
        end
        rd_req = '0;
        #1;
        chk("rr_last_valid", 64'(rd_rsp_valid), 64'h1);
        chk("rr_last_id", 64'(rd_rsp_id), 64'h3);
        chk("idle_rd_gnt", 64'(rd_gnt), 64'h0);

        wr_req = 4'b0100;
        wr_addr[2*AL +: AL] = 6'd5;
        wr_data[2*DL +: DL] = 32'hDEADBEEF;
        #1;
        chk("wtr_wr_gnt", 64'(wr_gnt), 64'h4);
        tick();
        wr_req = '0;
        rd_req = 4'b0010;
        rd_addr[1*AL +: AL] = 6'd5;
        #1;
        chk("wtr_rd_gnt", 64'(rd_gnt), 64'h2);
        chk("wtr_no_rsp", 64'(rd_rsp_valid), 64'h0);
        tick();
        rd_req = '0;
        #1;
        chk("wtr_valid", 64'(rd_rsp_valid), 64'h1);
        chk("wtr_id", 64'(rd_rsp_id), 64'h1);
        chk("wtr_data", 64'(rd_rsp_data), 64'hDEADBEEF);

        wr_req = 4'b0001;
        wr_addr[0 +: AL] = 6'd9;
        wr_data[0 +: DL] = 32'h11;
        #1;
        chk("pre_wr_gnt", 64'(wr_gnt), 64'h1);
        tick();
        wr_data[0 +: DL] = 32'h22;
        rd_req = 4'b1000;
        rd_addr[3*AL +: AL] = 6'd9;
        #1;
        chk("col_wr_gnt", 64'(wr_gnt), 64'h1);
        chk("col_rd_gnt", 64'(rd_gnt), 64'h8);
        tick();
        wr_req = '0;
        rd_req = 4'b0001;
        rd_addr[0 +: AL] = 6'd9;
        #1;
        chk("col_valid", 64'(rd_rsp_valid), 64'h1);
        chk("col_id", 64'(rd_rsp_id), 64'h3);
`ifdef BUF_ARB_BYPASS_EN
        chk("col_data", 64'(rd_rsp_data), 64'h22);
`else
        chk("col_data", 64'(rd_rsp_data), 64'h11);
`endif
        chk("after_rd_gnt", 64'(rd_gnt), 64'h1);
        tick();
        rd_req = 4'b0100;
        #1;
        chk("after_data", 64'(rd_rsp_data), 64'h22);
        chk("after_id", 64'(rd_rsp_id), 64'h0);
        chk("sp_setup_gnt", 64'(rd_gnt), 64'h4);
        tick();
        rd_req = 4'b0010;
        #1;
        chk("sp_gnt", 64'(rd_gnt), 64'h2);
        tick();
        rd_req = 4'b1111;
        #1;
        chk("sp_rsp_id", 64'(rd_rsp_id), 64'h1);
        chk("sp_next_gnt", 64'(rd_gnt), 64'h4);
        tick();

        reset = 1'b1;
        rd_req = 4'b0001;
        wr_req = 4'b0001;
        wr_data[0 +: DL] = 32'h99;
        #1;
        chk("mid_rd_gnt", 64'(rd_gnt), 64'h0);
        chk("mid_wr_gnt", 64'(wr_gnt), 64'h0);
        tick();
        reset = 1'b0;
        wr_req = '0;
        #1;
        chk("mid_rsp_valid", 64'(rd_rsp_valid), 64'h0);
        chk("mid_post_gnt", 64'(rd_gnt), 64'h1);
        tick();
        rd_req = '0;
        #1;
        chk("mid_post_valid", 64'(rd_rsp_valid), 64'h1);
        chk("mid_post_data", 64'(rd_rsp_data), 64'h22);
        tick();
        chk("end_valid", 64'(rd_rsp_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buffer_port_arbiter.md
# buffer_port_arbiter

Round-robin arbiter that shares one simple-dual-port `buffer` instance between `numReq` requesters. The write port and the read port are arbitrated independently. Read responses come back one cycle after grant, tagged with the requester index. It sits between the PE-side memory clients and a shared weight/data buffer, so that several units can use a single RAM.

## Interface
- `numReq`, 4: number of requesters; must be ≥2.
- `idLen`, 2: requester index width; equals ceil(log2(`numReq`)).
- `addrLen`, 6: buffer address width.
- `dataLen`, 32: buffer data width.
- `ram_type`, "distributed": passed to the buffer's `ram_style`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_req` in `numReq`: per-requester write request; held until granted.
- `wr_addr` in `numReq*addrLen`: flattened write addresses; requester i is at slice [i*addrLen +: addrLen].
- `wr_data` in `numReq*dataLen`: flattened write data.
- `wr_gnt` out `numReq`: one-hot or zero. Combinational; the write is committed on the edge that ends the cycle.
- `rd_req` in `numReq`: per-requester read request; held until granted.
- `rd_addr` in `numReq*addrLen`: flattened read addresses.
- `rd_gnt` out `numReq`: one-hot or zero. Combinational; the read is accepted this cycle.
- `rd_rsp_valid` out 1: registered; read data is valid this cycle.
- `rd_rsp_id` out `idLen`: registered; index of the requester that owns the response.
- `rd_rsp_data` out `dataLen`: read data; qualified by `rd_rsp_valid`.

## Operation
- Two independent round-robin arbiters: one for the write port, one for the read port. Each has a pointer `ptr` (`idLen` bits).
- Grant rule: search from `ptr` upward, modulo `numReq`. The first requester with its request bit set is granted. No request means no grant.
- Pointer update: on a grant to index g, `ptr` becomes (g+1) mod `numReq`. With no grant, `ptr` is unchanged. This guarantees no requester waits more than `numReq`-1 grants.
- Write path:
  - The granted requester's address and data drive the buffer write port.
  - Buffer `wrt` equals the OR of `wr_gnt`.
- Read path:
  - The granted requester's address drives the buffer `rd_addr`.
  - A pipeline register captures `{valid, id}` of the grant.
  - The buffer's registered `data_out` drives `rd_rsp_data`.
- Collision: a write and a read to the same address in the same cycle are both granted. Returned data depends on `BUF_ARB_BYPASS_EN` (see Configuration).
- A requester may assert `wr_req` and `rd_req` together; the two ports serve it independently.
- Request, address and data inputs are sampled only in the grant cycle. Changing them while ungranted is legal.

## Timing
- Write: grant in cycle t (combinational). Memory is updated at the end of t. A read granted in t+1 returns the new data.
- Read: grant in cycle t. In cycle t+1: `rd_rsp_valid`=1, `rd_rsp_id`=g, `rd_rsp_data`=mem[addr]. Latency is fixed at 1 cycle.
- Throughput: one read and one write per cycle, sustained.
- Reset values:
  - Both `ptr` = 0.
  - `rd_rsp_valid` = 0 and `rd_rsp_id` = 0.
  - `rd_rsp_data` is undefined; consumers must qualify it with `rd_rsp_valid`.
  - `wr_gnt` and `rd_gnt` are 0 while `reset` is high, regardless of requests.
  - Memory contents are not cleared.
- Reset mid-operation: a read granted in the cycle where `reset` rises produces no response. A write granted in that cycle is suppressed.
- No backpressure on responses: the requester must accept the response in cycle t+1.

## Configuration
- `BUF_ARB_BYPASS_EN` defined:
  - A same-cycle write/read to the same address forwards the write data. `rd_rsp_data` in t+1 equals the written value.
  - Implemented with a registered address-match flag and a registered copy of the write data, muxed after the buffer output.
- `BUF_ARB_BYPASS_EN` undefined: a same-cycle collision returns the old memory contents (native read-before-write behaviour). No extra registers.

## Structure
- Shared package `buffer_arb_pkg` holds:
  - the default widths;
  - the `idLen` derivation function (clog2);
  - a typedef for the response tag struct `{valid, id}`.
- Sub-module `rr_arbiter` (parameters `numReq`, `idLen`; ports `clk`, `reset`, `req`, `gnt`, `gnt_id`, `gnt_valid`) is instantiated twice.
- The RAM is one internal instance of `buffer` with `addrLen`, `dataLen`, `ram_type` passed through.

## Test plan
- **Reset:** hold `reset` 3 cycles with all requests high. Require `wr_gnt`=0, `rd_gnt`=0, `rd_rsp_valid`=0. After release, the first grant is to index 0.
- **Round-robin fairness:** hold `rd_req`=4'b1111 for 8 cycles. Require `rd_gnt` sequence 0001,0010,0100,1000,0001,… and `rd_rsp_id` 0,1,2,3,… one cycle later.
- **Write-then-read:**
  - requester 2 writes 0xDEADBEEF to address 5 in cycle t;
  - requester 1 reads address 5 in t+1;
  - require `rd_rsp_valid`=1, `rd_rsp_id`=1, `rd_rsp_data`=0xDEADBEEF in t+2.
- **Collision:** preload address 9 with 0x11, then write 0x22 and read address 9 in the same cycle. Require the response to be 0x11 without `BUF_ARB_BYPASS_EN` and 0x22 with it.
- **Sparse requests:** `ptr`=3, only requester 1 requesting. Require an immediate grant to 1, then `ptr`=2.
- **Reset mid-read:** read granted in the cycle `reset` asserts. Require `rd_rsp_valid`=0 in the following cycle.
